// File: rtl/alu_seq_pkg.sv
// Shared constants, opcodes, FSM state encoding and response payload for alu_cmd_sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREG   = 4;
  localparam int unsigned REG_AW = $clog2(NREG);
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_INV  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_AND  = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL4 = 3'b100;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b101;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b110;
  localparam logic [OP_W-1:0] OP_NONE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x DATA_W register file: two asynchronous read ports, one synchronous write port.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a_c,
  output logic [DATA_W-1:0] rdata_b_c
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a_c = regs_q[raddr_a];
  assign rdata_b_c = regs_q[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer driving an external combinational ALU from a small register file.
// Optional macro ALU_SEQ_FLAGS_EN adds registered rsp_zero / rsp_neg response flags.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [REG_AW-1:0] cmd_srca,
  input  logic [REG_AW-1:0] cmd_srcb,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [REG_AW-1:0] rsp_dst
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              rsp_zero,
  output logic              rsp_neg
`endif
);

  state_t            state_q;
  state_t            state_d;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              ld_alu;
  logic [REG_AW-1:0] dst_q;
  rsp_t              rsp_q;

  alu_seq_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr_a   (cmd_srca),
    .raddr_b   (cmd_srcb),
    .rdata_a_c (rd_a),
    .rdata_b_c (rd_b)
  );

  // Ready depends on state only; gated by reset so nothing is offered while held in reset.
  assign cmd_ready = (state_q == ST_IDLE) && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rf_we    = 1'b0;
    rf_waddr = dst_q;
    rf_wdata = alu_out;
    ld_alu   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rf_waddr = cmd_dst;
        if (cmd_valid) begin
          if (cmd_load) begin
            rf_we    = 1'b1;
            rf_wdata = cmd_imm;
            state_d  = ST_RESP;
          end else begin
            ld_alu  = 1'b1;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        rf_we   = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU operand/opcode registers and the response register, captured alongside the write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= OP_NONE;
      dst_q      <= '0;
      rsp_q      <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      rsp_valid <= (state_d == ST_RESP);
      if (ld_alu) begin
        alu_a      <= rd_a;
        alu_b      <= rd_b;
        alu_opcode <= cmd_op;
        dst_q      <= cmd_dst;
      end
      if (rf_we) begin
        rsp_q.dst  <= rf_waddr;
        rsp_q.data <= rf_wdata;
      end
    end
  end

  assign rsp_data = rsp_q.data;
  assign rsp_dst  = rsp_q.dst;

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
    end else if (rf_we) begin
      rsp_zero <= (rf_wdata == '0);
      rsp_neg  <= rf_wdata[DATA_W-1];
    end
  end
`endif

endmodule
